program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_if.sv | 29 ++
 rtl/program_loader.sv | 133 +++++++++++++
 2 files changed

// File: rtl/program_loader_if.sv
// Bundle of the program loader's control, word-stream, instruction-memory and
// status signals; the loader takes the slave view, the driving side the master view.
interface program_loader_if;
    logic        load_start;
    logic [8:0]  load_len;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] checksum;

    modport slave (
        input  load_start, load_len, s_valid, s_data,
        output s_ready, imem_we, imem_addr, imem_wdata,
               cpu_rst, busy, done, err, checksum
    );

    modport master (
        output load_start, load_len, s_valid, s_data,
        input  s_ready, imem_we, imem_addr, imem_wdata,
               cpu_rst, busy, done, err, checksum
    );
endinterface

// File: rtl/program_loader.sv
// Streams a program into instruction memory, holding the CPU in reset while loading,
// then flushes for two cycles and releases the CPU.
module program_loader #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    program_loader_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } state_e;

    localparam logic [9:0] LEN_MAX = 10'(DEPTH);

    state_e      state_q, state_d;
    logic [8:0]  len_q, len_d;
    logic [8:0]  cnt_q, cnt_d;
    logic        flush_q, flush_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] sum_q, sum_d;
    logic        err_q, err_d;

    logic can_start;
    logic len_ok;
    logic start_ok;
    logic start_bad;
    logic word_acc;
    logic last_word;

    // load_start is only honoured while no load is in flight.
    assign can_start = (state_q == IDLE) || (state_q == RUN);
    assign len_ok    = (bus.load_len != 9'd0) && ({1'b0, bus.load_len} <= LEN_MAX);
    assign start_ok  = bus.load_start && can_start && len_ok;
    assign start_bad = bus.load_start && can_start && !len_ok;
    assign word_acc  = (state_q == LOAD) && bus.s_valid;
    assign last_word = (cnt_q == (len_q - 9'd1));

    // NOTE: every variable driven here gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        flush_d = flush_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sum_d   = sum_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE, RUN: begin
                if (start_ok) begin
                    state_d = LOAD;
                    len_d   = bus.load_len;
                    cnt_d   = 9'd0;
                    sum_d   = 32'd0;
                    err_d   = 1'b0;
                end else if (start_bad) begin
                    err_d = 1'b1;
                end
            end

            LOAD: begin
                if (word_acc) begin
                    we_d    = 1'b1;
                    addr_d  = BASE_ADDR + {21'd0, cnt_q, 2'b00};
                    wdata_d = bus.s_data;
                    sum_d   = sum_q + bus.s_data;
                    cnt_d   = cnt_q + 9'd1;
                    if (last_word) begin
                        state_d = FLUSH;
                        flush_d = 1'b0;
                    end
                end
            end

            FLUSH: begin
                // Two cycles: the first carries the final write strobe.
                if (flush_q) begin
                    state_d = RUN;
                end else begin
                    flush_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            len_q   <= 9'd0;
            cnt_q   <= 9'd0;
            flush_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= 32'd0;
            sum_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
        end
    end

    assign bus.s_ready    = (state_q == LOAD);
    assign bus.busy       = (state_q == LOAD) || (state_q == FLUSH);
    assign bus.cpu_rst    = (state_q != RUN);
    assign bus.done       = (state_q == RUN);
    assign bus.err        = err_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.checksum   = sum_q;

endmodule
